// File: rtl/vm_pkg.sv
// Shared types and default coin values for the multi-product vending machine.
package vm_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CREDIT = 2'd1,
    ST_VEND   = 2'd2,
    ST_CHANGE = 2'd3
  } vm_state_e;

  typedef enum logic [1:0] {
    COIN0        = 2'd0,
    COIN1        = 2'd1,
    COIN2        = 2'd2,
    COIN_INVALID = 2'd3
  } coin_type_e;

  localparam int COIN0_VAL_DEF = 5;
  localparam int COIN1_VAL_DEF = 10;
  localparam int COIN2_VAL_DEF = 25;

  // Selector width that stays legal for a single-product build.
  function automatic int sel_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/vending_machine_multi_if.sv
// Coin-acceptor / selector / dispenser signal bundle; suffixes are relative to the machine.
interface vending_machine_multi_if
  import vm_pkg::*;
#(
  parameter int N_ITEMS  = 4,
  parameter int CREDIT_W = 8
);
  localparam int SEL_W = sel_width(N_ITEMS);

  logic                coin_valid_i;
  logic [1:0]          coin_type_i;
  logic                sel_valid_i;
  logic [SEL_W-1:0]    sel_item_i;
  logic                cancel_i;
  logic                restock_i;
  logic                change_ready_i;
  logic                coin_reject_o;
  logic                sel_nack_o;
  logic                vend_valid_o;
  logic [SEL_W-1:0]    vend_item_o;
  logic                change_valid_o;
  logic [1:0]          change_coin_o;
  logic [CREDIT_W-1:0] credit_o;
  logic [N_ITEMS-1:0]  sold_out_o;
  logic                busy_o;

  modport master (
    output coin_valid_i, coin_type_i, sel_valid_i, sel_item_i, cancel_i, restock_i,
           change_ready_i,
    input  coin_reject_o, sel_nack_o, vend_valid_o, vend_item_o, change_valid_o,
           change_coin_o, credit_o, sold_out_o, busy_o
  );

  modport slave (
    input  coin_valid_i, coin_type_i, sel_valid_i, sel_item_i, cancel_i, restock_i,
           change_ready_i,
    output coin_reject_o, sel_nack_o, vend_valid_o, vend_item_o, change_valid_o,
           change_coin_o, credit_o, sold_out_o, busy_o
  );
endinterface

// File: rtl/vm_change_picker.sv
// Greedy change selector: largest coin not exceeding the credit (value 0 when none fits).
module vm_change_picker
  import vm_pkg::*;
#(
  parameter int CREDIT_W  = 8,
  parameter int COIN0_VAL = COIN0_VAL_DEF,
  parameter int COIN1_VAL = COIN1_VAL_DEF,
  parameter int COIN2_VAL = COIN2_VAL_DEF
) (
  input  logic [CREDIT_W-1:0] credit_i,
  output logic [1:0]          coin_o,
  output logic [CREDIT_W-1:0] value_o
);

  always_comb begin
    coin_o  = COIN0;
    value_o = '0;
    if (credit_i >= CREDIT_W'(COIN2_VAL)) begin
      coin_o  = COIN2;
      value_o = CREDIT_W'(COIN2_VAL);
    end else if (credit_i >= CREDIT_W'(COIN1_VAL)) begin
      coin_o  = COIN1;
      value_o = CREDIT_W'(COIN1_VAL);
    end else if (credit_i >= CREDIT_W'(COIN0_VAL)) begin
      coin_o  = COIN0;
      value_o = CREDIT_W'(COIN0_VAL);
    end
  end

endmodule

// File: rtl/vending_machine_multi.sv
// Multi-product coin vending controller: credit accumulation, per-item stock,
// vend pulse and greedy one-coin-per-handshake change return.
module vending_machine_multi
  import vm_pkg::*;
#(
  parameter int                        N_ITEMS     = 4,
  parameter int                        CREDIT_W    = 8,
  parameter logic [N_ITEMS*CREDIT_W-1:0] ITEM_PRICES = 32'h28_19_14_0F,
  parameter int                        COIN0_VAL   = COIN0_VAL_DEF,
  parameter int                        COIN1_VAL   = COIN1_VAL_DEF,
  parameter int                        COIN2_VAL   = COIN2_VAL_DEF,
  parameter int                        MAX_CREDIT  = 100,
  parameter int                        STOCK_W     = 4,
  parameter int                        STOCK_INIT  = 8
) (
  input logic                    clock_i,
  input logic                    reset_ni,
  vending_machine_multi_if.slave bus
);

  localparam int SEL_W = sel_width(N_ITEMS);

  vm_state_e           state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [STOCK_W-1:0]  stock_q [N_ITEMS];
  logic [STOCK_W-1:0]  stock_d [N_ITEMS];
  logic                coin_reject_q, coin_reject_d;
  logic                sel_nack_q, sel_nack_d;
  logic                vend_valid_q, vend_valid_d;
  logic [SEL_W-1:0]    vend_item_q, vend_item_d;
  logic                change_valid_q, change_valid_d;
  logic [1:0]          change_coin_q, change_coin_d;

  logic [1:0]          cur_coin, rem_coin;
  logic [CREDIT_W-1:0] cur_val, rem_val, remainder;
  logic [CREDIT_W:0]   coin_sum;
  logic [CREDIT_W-1:0] sel_price;
  logic                sel_in_range, sel_ok, coin_ok;

  function automatic logic [CREDIT_W-1:0] coin_value(input logic [1:0] t);
    case (coin_type_e'(t))
      COIN0:   return CREDIT_W'(COIN0_VAL);
      COIN1:   return CREDIT_W'(COIN1_VAL);
      COIN2:   return CREDIT_W'(COIN2_VAL);
      default: return '0;
    endcase
  endfunction

  // Coin the dispenser currently owes, and the one after it once that is taken.
  vm_change_picker #(
    .CREDIT_W(CREDIT_W), .COIN0_VAL(COIN0_VAL), .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL)
  ) u_pick_cur (
    .credit_i(credit_q), .coin_o(cur_coin), .value_o(cur_val)
  );

  assign remainder = credit_q - cur_val;

  vm_change_picker #(
    .CREDIT_W(CREDIT_W), .COIN0_VAL(COIN0_VAL), .COIN1_VAL(COIN1_VAL), .COIN2_VAL(COIN2_VAL)
  ) u_pick_rem (
    .credit_i(remainder), .coin_o(rem_coin), .value_o(rem_val)
  );

  // One extra bit on the sum so the ceiling test cannot be fooled by wrap-around.
  assign coin_sum     = {1'b0, credit_q} + {1'b0, coin_value(bus.coin_type_i)};
  assign coin_ok      = (bus.coin_type_i != COIN_INVALID) &&
                        (coin_sum <= (CREDIT_W+1)'(MAX_CREDIT));
  assign sel_in_range = int'(bus.sel_item_i) < N_ITEMS;
  assign sel_price    = sel_in_range ?
                        ITEM_PRICES[int'(bus.sel_item_i)*CREDIT_W +: CREDIT_W] : '0;
  assign sel_ok       = sel_in_range && (stock_q[bus.sel_item_i] != '0) &&
                        (credit_q >= sel_price);

  always_comb begin
    state_d        = state_q;
    credit_d       = credit_q;
    stock_d        = stock_q;
    coin_reject_d  = 1'b0;
    sel_nack_d     = 1'b0;
    vend_valid_d   = 1'b0;
    vend_item_d    = vend_item_q;
    change_valid_d = change_valid_q;
    change_coin_d  = change_coin_q;

    case (state_q)
      ST_IDLE, ST_CREDIT: begin
        if (bus.cancel_i && (state_q == ST_CREDIT)) begin
          state_d        = ST_CHANGE;
          change_valid_d = 1'b1;
          change_coin_d  = cur_coin;
          coin_reject_d  = bus.coin_valid_i;
        end else if (bus.sel_valid_i) begin
          // The selection owns this cycle, so a simultaneous coin is handed back.
          coin_reject_d = bus.coin_valid_i;
          if (sel_ok) begin
            state_d                  = ST_VEND;
            vend_valid_d             = 1'b1;
            vend_item_d              = bus.sel_item_i;
            stock_d[bus.sel_item_i]  = stock_q[bus.sel_item_i] - STOCK_W'(1);
            credit_d                 = credit_q - sel_price;
          end else begin
            sel_nack_d = 1'b1;
          end
        end else if (bus.coin_valid_i) begin
          if (coin_ok) begin
            credit_d = coin_sum[CREDIT_W-1:0];
            state_d  = ST_CREDIT;
          end else begin
            coin_reject_d = 1'b1;
          end
        end
        if ((state_q == ST_IDLE) && bus.restock_i) begin
          for (int i = 0; i < N_ITEMS; i++) stock_d[i] = STOCK_W'(STOCK_INIT);
        end
      end

      ST_VEND: begin
        coin_reject_d = bus.coin_valid_i;
        sel_nack_d    = bus.sel_valid_i;
        if (credit_q != '0) begin
          state_d        = ST_CHANGE;
          change_valid_d = 1'b1;
          change_coin_d  = cur_coin;
        end else begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        coin_reject_d = bus.coin_valid_i;
        sel_nack_d    = bus.sel_valid_i;
        if (change_valid_q && bus.change_ready_i) begin
          if (rem_val != '0) begin
            credit_d      = remainder;
            change_coin_d = rem_coin;
          end else begin
            credit_d       = '0;
            state_d        = ST_IDLE;
            change_valid_d = 1'b0;
            change_coin_d  = COIN0;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clock_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q        <= ST_IDLE;
      credit_q       <= '0;
      coin_reject_q  <= 1'b0;
      sel_nack_q     <= 1'b0;
      vend_valid_q   <= 1'b0;
      vend_item_q    <= '0;
      change_valid_q <= 1'b0;
      change_coin_q  <= COIN0;
      for (int i = 0; i < N_ITEMS; i++) stock_q[i] <= STOCK_W'(STOCK_INIT);
    end else begin
      state_q        <= state_d;
      credit_q       <= credit_d;
      coin_reject_q  <= coin_reject_d;
      sel_nack_q     <= sel_nack_d;
      vend_valid_q   <= vend_valid_d;
      vend_item_q    <= vend_item_d;
      change_valid_q <= change_valid_d;
      change_coin_q  <= change_coin_d;
      stock_q        <= stock_d;
    end
  end

  assign bus.coin_reject_o  = coin_reject_q;
  assign bus.sel_nack_o     = sel_nack_q;
  assign bus.vend_valid_o   = vend_valid_q;
  assign bus.vend_item_o    = vend_item_q;
  assign bus.change_valid_o = change_valid_q;
  assign bus.change_coin_o  = change_coin_q;
  assign bus.credit_o       = credit_q;
  assign bus.busy_o         = (state_q == ST_VEND) || (state_q == ST_CHANGE);

  for (genvar g = 0; g < N_ITEMS; g++) begin : g_sold_out
    assign bus.sold_out_o[g] = (stock_q[g] == '0);
  end

endmodule

// File: tb/tb_vending_machine_multi.sv
// Bench for vending_machine_multi: directed scenarios then random traffic,
// every cycle compared against a coin-queue reference model.
module tb_vending_machine_multi;
  import vm_pkg::*;

  localparam int N  = 4;
  localparam int CW = 8;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  vending_machine_multi_if #(.N_ITEMS(N), .CREDIT_W(CW)) bus ();

  vending_machine_multi #(.N_ITEMS(N), .CREDIT_W(CW)) dut (
    .clock_i (clk),
    .reset_ni(rst_n),
    .bus     (bus)
  );

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Reference model: credit as an integer, stock per item, and the pending
  // change as a queue of coin types produced greedily from the owed amount.
  int price [N] = '{15, 20, 25, 40};
  int m_credit;
  int m_stock [N];
  bit m_vend;
  int m_vitem;
  int m_q[$];
  bit e_rej, e_nack;

  function automatic int cval(input int t);
    case (t)
      0: return 5;
      1: return 10;
      2: return 25;
      default: return 0;
    endcase
  endfunction

  function automatic void greedy(input int c);
    m_q.delete();
    while (c >= 25) begin m_q.push_back(2); c -= 25; end
    while (c >= 10) begin m_q.push_back(1); c -= 10; end
    while (c >= 5)  begin m_q.push_back(0); c -= 5;  end
  endfunction

  function automatic void m_reset();
    m_credit = 0;
    m_vend   = 0;
    m_vitem  = 0;
    m_q.delete();
    e_rej  = 0;
    e_nack = 0;
    for (int i = 0; i < N; i++) m_stock[i] = 8;
  endfunction

  function automatic void m_step(input bit cv, input int ct, input bit sv, input int si,
                                 input bit cn, input bit rs, input bit rdy);
    bit idle_before;
    idle_before = !m_vend && (m_q.size() == 0) && (m_credit == 0);
    e_rej  = 0;
    e_nack = 0;
    if (m_vend) begin
      m_vend = 0;
      e_rej  = cv;
      e_nack = sv;
      greedy(m_credit);
    end else if (m_q.size() > 0) begin
      e_rej  = cv;
      e_nack = sv;
      if (rdy) begin
        m_credit -= cval(m_q[0]);
        void'(m_q.pop_front());
      end
    end else begin
      if (cn && m_credit > 0) begin
        greedy(m_credit);
        e_rej = cv;
      end else if (sv) begin
        e_rej = cv;
        if (si < N && m_stock[si] > 0 && m_credit >= price[si]) begin
          m_vend   = 1;
          m_vitem  = si;
          m_stock[si]--;
          m_credit -= price[si];
        end else begin
          e_nack = 1;
        end
      end else if (cv) begin
        if (ct != 3 && m_credit + cval(ct) <= 100) m_credit += cval(ct);
        else e_rej = 1;
      end
      if (idle_before && rs) for (int i = 0; i < N; i++) m_stock[i] = 8;
    end
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    assert (got === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic check_all(input string tag);
    logic [N-1:0] so;
    for (int i = 0; i < N; i++) so[i] = (m_stock[i] == 0);
    chk({tag, "/credit"},       32'(bus.credit_o),       32'(m_credit));
    chk({tag, "/coin_reject"},  32'(bus.coin_reject_o),  32'(e_rej));
    chk({tag, "/sel_nack"},     32'(bus.sel_nack_o),     32'(e_nack));
    chk({tag, "/vend_valid"},   32'(bus.vend_valid_o),   32'(m_vend));
    chk({tag, "/vend_item"},    32'(bus.vend_item_o),    32'(m_vitem));
    chk({tag, "/change_valid"}, 32'(bus.change_valid_o), 32'(m_q.size() > 0));
    chk({tag, "/change_coin"},  32'(bus.change_coin_o),  32'((m_q.size() > 0) ? m_q[0] : 0));
    chk({tag, "/sold_out"},     32'(bus.sold_out_o),     32'(so));
    chk({tag, "/busy"},         32'(bus.busy_o),         32'(m_vend || m_q.size() > 0));
  endtask

  task automatic step(input bit cv, input int ct, input bit sv, input int si,
                      input bit cn, input bit rs, input bit rdy, input string tag);
    logic [1:0] ct2;
    logic [1:0] si2;
    ct2 = ct[1:0];
    si2 = si[1:0];
    bus.coin_valid_i   = cv;
    bus.coin_type_i    = ct2;
    bus.sel_valid_i    = sv;
    bus.sel_item_i     = si2;
    bus.cancel_i       = cn;
    bus.restock_i      = rs;
    bus.change_ready_i = rdy;
    @(posedge clk);
    m_step(cv, ct, sv, si, cn, rs, rdy);
    #1;
    check_all(tag);
  endtask

  task automatic coin(input int t, input string tag);  step(1, t, 0, 0, 0, 0, 1, tag); endtask
  task automatic sel(input int i, input string tag);   step(0, 0, 1, i, 0, 0, 1, tag); endtask
  task automatic cancel(input string tag);             step(0, 0, 0, 0, 1, 0, 1, tag); endtask
  task automatic idle(input bit rdy, input string tag); step(0, 0, 0, 0, 0, 0, rdy, tag); endtask

  task automatic drain(input string tag);
    for (int k = 0; k < 20 && (m_vend || m_q.size() > 0); k++) idle(1, tag);
    chk({tag, "/drained_busy"}, 32'(bus.busy_o), 32'd0);
  endtask

  initial begin
    bus.coin_valid_i   = 0;
    bus.coin_type_i    = 0;
    bus.sel_valid_i    = 0;
    bus.sel_item_i     = 0;
    bus.cancel_i       = 0;
    bus.restock_i      = 0;
    bus.change_ready_i = 0;
    m_reset();
    repeat (2) @(posedge clk);
    #1;
    check_all("reset");
    rst_n = 1'b1;

    // 25 + 25, buy item 3 at 40, one 10 back
    coin(2, "t1_c25a");
    coin(2, "t1_c25b");
    chk("t1_credit50", 32'(bus.credit_o), 32'd50);
    sel(3, "t1_sel3");
    chk("t1_vend_item3", 32'(bus.vend_item_o), 32'd3);
    chk("t1_vend_valid", 32'(bus.vend_valid_o), 32'd1);
    idle(1, "t1_vend");
    chk("t1_change10", 32'(bus.change_coin_o), 32'd1);
    idle(1, "t1_change");
    chk("t1_idle_credit", 32'(bus.credit_o), 32'd0);

    // Insufficient credit, then cancel
    coin(1, "t2_c10");
    sel(0, "t2_sel0");
    chk("t2_nack", 32'(bus.sel_nack_o), 32'd1);
    chk("t2_credit10", 32'(bus.credit_o), 32'd10);
    cancel("t2_cancel");
    chk("t2_refund10", 32'(bus.change_coin_o), 32'd1);
    drain("t2");

    // Ceiling
    coin(2, "t3_a"); coin(2, "t3_b"); coin(2, "t3_c"); coin(1, "t3_d"); coin(0, "t3_e");
    coin(2, "t3_over");
    chk("t3_reject", 32'(bus.coin_reject_o), 32'd1);
    chk("t3_credit90", 32'(bus.credit_o), 32'd90);
    coin(1, "t3_to100");
    chk("t3_credit100", 32'(bus.credit_o), 32'd100);
    cancel("t3_cancel");
    drain("t3");

    // Empty item 2, nack, restock
    for (int k = 0; k < 8; k++) begin
      coin(2, "t4_coin");
      sel(2, "t4_sel");
      idle(1, "t4_vend");
    end
    chk("t4_sold_out2", 32'(bus.sold_out_o[2]), 32'd1);
    coin(2, "t4_coin_x");
    sel(2, "t4_sel_empty");
    chk("t4_nack_empty", 32'(bus.sel_nack_o), 32'd1);
    cancel("t4_cancel");
    drain("t4");
    step(0, 0, 0, 0, 0, 1, 1, "t4_restock");
    chk("t4_restocked", 32'(bus.sold_out_o), 32'd0);

    // Backpressure on change: 45 held as a 25 coin until ready
    coin(2, "t5_a"); coin(1, "t5_b"); coin(1, "t5_c");
    step(0, 0, 0, 0, 1, 0, 0, "t5_cancel");
    for (int k = 0; k < 3; k++) begin
      idle(0, "t5_stall");
      chk("t5_hold_coin", 32'(bus.change_coin_o), 32'd2);
    end
    idle(1, "t5_r25");
    idle(1, "t5_r10a");
    idle(1, "t5_r10b");
    chk("t5_idle", 32'(bus.busy_o), 32'd0);

    // Async reset in the middle of returning change
    coin(2, "t6_a"); coin(1, "t6_b"); coin(0, "t6_c");
    cancel("t6_cancel");
    idle(1, "t6_r25");
    #2 rst_n = 1'b0;
    #1;
    chk("t6_rst_credit", 32'(bus.credit_o), 32'd0);
    chk("t6_rst_cv", 32'(bus.change_valid_o), 32'd0);
    chk("t6_rst_busy", 32'(bus.busy_o), 32'd0);
    m_reset();
    check_all("t6_rst");
    @(posedge clk);
    #1;
    check_all("t6_rst_hold");
    #2 rst_n = 1'b1;

    // Random traffic
    for (int n = 0; n < 1500; n++) begin
      int r;
      bit rdy;
      r   = int'($urandom_range(0, 99));
      rdy = ($urandom_range(0, 3) != 0);
      if (r < 45)      step(1, int'($urandom_range(0, 3)), 0, 0, 0, 0, rdy, "rnd_coin");
      else if (r < 65) step(0, 0, 1, int'($urandom_range(0, N-1)), 0, 0, rdy, "rnd_sel");
      else if (r < 70) step($urandom_range(0, 1) == 1, int'($urandom_range(0, 3)), 0, 0, 1, 0,
                            rdy, "rnd_cancel");
      else if (r < 73) step(0, 0, 0, 0, 0, 1, rdy, "rnd_restock");
      else             step(0, 0, 0, 0, 0, 0, rdy, "rnd_idle");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/vending_machine_multi.md
Name: vending_machine_multi

Overview:
- Parametrised successor to the single-product coin vending FSM.
- Accepts coins of three denominations into a credit register and sells one of N_ITEMS products, each with its own price and stock counter.
- Returns change greedily, one coin per handshake, and supports cancel/refund.
- Sits between the coin acceptor front-end and the product/coin dispenser actuators.

Parameters:
- N_ITEMS, 4, number of products
- CREDIT_W, 8, width of credit, price and change arithmetic
- ITEM_PRICES, 32'h28_19_14_0F, packed prices; item i at [i*CREDIT_W +: CREDIT_W]; default 15, 20, 25, 40
- COIN0_VAL / COIN1_VAL / COIN2_VAL, 5 / 10 / 25, coin values in credit units
- MAX_CREDIT, 100, credit ceiling
- STOCK_W, 4, stock counter width
- STOCK_INIT, 8, stock loaded at reset and on restock

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- coin_valid  in  1  coin present this cycle
- coin_type  in  2  0 = COIN0, 1 = COIN1, 2 = COIN2, 3 = invalid
- sel_valid  in  1  selection request
- sel_item  in  clog2(N_ITEMS)  selected product
- cancel  in  1  refund request
- restock  in  1  reload all stock
- change_ready  in  1  coin dispenser can accept a coin
- coin_reject  out  1  one-cycle pulse: coin returned unaccepted
- sel_nack  out  1  one-cycle pulse: selection refused
- vend_valid  out  1  one-cycle pulse: dispense product
- vend_item  out  clog2(N_ITEMS)  product being dispensed
- change_valid  out  1  change coin offered
- change_coin  out  2  denomination offered (0..2)
- credit  out  CREDIT_W  current credit
- sold_out  out  N_ITEMS  bit i set when stock[i] == 0
- busy  out  1  high in VEND or CHANGE

Behaviour:
- Reset (reset low, async):
  - state = IDLE; credit = 0; all pulses, change_valid, change_coin, vend_item = 0.
  - Every stock[i] = STOCK_INIT, so sold_out = 0.
- All outputs are registered; sold_out and busy are decoded from registers.
- States:
  - IDLE: credit == 0.
  - CREDIT: credit > 0, accepting coins and selections.
  - VEND: one cycle.
  - CHANGE: returning coins.
- Priority in IDLE/CREDIT, one event per cycle: cancel > sel_valid > coin_valid.
  - A coin arriving in the same cycle as an accepted cancel or selection gets coin_reject.
- Coin acceptance (IDLE/CREDIT):
  - Condition: coin_type != 3 and credit + value <= MAX_CREDIT.
  - Action: credit += value next cycle; state becomes CREDIT.
  - Otherwise coin_reject pulses the next cycle and credit is unchanged.
- Selection (IDLE/CREDIT):
  - If stock[sel_item] == 0, or credit < price, or sel_item >= N_ITEMS: sel_nack pulses, state unchanged.
  - Otherwise go to VEND. In VEND: vend_valid = 1, vend_item = sel_item, stock decremented, credit -= price.
  - Next state is CHANGE if the remainder > 0, else IDLE.
- Cancel: in CREDIT go to CHANGE with full credit; in IDLE ignored.
- CHANGE:
  - change_coin is the largest denomination <= credit; change_valid = 1.
  - On change_valid && change_ready at an edge: credit -= value and a new coin is recomputed.
  - When credit reaches 0: change_valid drops the same edge and state becomes IDLE.
  - If change_ready stays low, change_valid and change_coin hold stable.
- coin_valid, sel_valid and cancel in VEND/CHANGE:
  - Coins get coin_reject; selections get sel_nack; cancel is ignored.
- restock: honoured only in IDLE (all stock = STOCK_INIT); ignored elsewhere.
- Width rules:
  - Credit arithmetic is unsigned CREDIT_W bits and never wraps, because the ceiling check uses a CREDIT_W+1-bit sum.
  - Stock saturates at 0.
- Legality: all prices and coin values are multiples of COIN0_VAL, so greedy change always terminates. MAX_CREDIT < 2^CREDIT_W.
- Reset mid-CHANGE: pending change is lost; all outputs go to reset values immediately.

Decomposition:
- Package vm_pkg holds:
  - the state enum (IDLE, CREDIT, VEND, CHANGE);
  - the coin_type enum;
  - the coin value localparam defaults.
- Sub-module vm_change_picker: combinational greedy denomination select; inputs credit, output coin type and value. Reused by cancel and post-vend paths.

Test Plan:
- Insert 25 then 25 (credit 50), select item 3 (price 40): vend_valid with vend_item = 3 one cycle after selection, then change_coin = 1 (10) once, then IDLE with credit 0; stock[3] = 7.
- Insert 10, select item 0 (price 15): sel_nack, credit stays 10. Then cancel: one change_coin = 1 with change_ready = 1, then IDLE.
- Credit 90, insert 25: coin_reject, credit stays 90. Insert 10: credit 100.
- Vend item 2 eight times: after the 8th, sold_out[2] = 1 and a further select of item 2 gives sel_nack. restock in IDLE clears sold_out[2].
- Credit 45, cancel with change_ready low for 3 cycles: change_valid = 1 and change_coin = 2 held stable. Then ready high: coins 25, 10, 10 returned, then IDLE.
- Credit 40 returning change, reset asserted asynchronously mid-CHANGE: outputs zero before the next clock edge; stock returns to 8.
